e_seek: RTL and testbench

Sequential, parametrised successor to the `e_cell` select logic. Given a bit vector and a one-hot start position, it finds the first clear bit after the start position, scanning from high index toward low. Arbitrary W is supported by examining C positions per cycle, with optional wrap-around past index 0. It sits behind valid/ready request and response handshakes, so it can serve a slot allocator or ring scheduler without a W-wide combinational chain.

---
 rtl/e_seek.sv | 223 ++++++++++++++++++++++
 tb/tb_e_seek.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/e_seek.sv
// e_seek: sequential first-clear-bit finder.
//
// Given an occupancy vector x and a one-hot start position s, the block
// finds the first clear bit below s (index s-1, s-2, ...). With WRAP=1 the
// search continues from W-1 down to s+1. C positions are examined per SCAN
// cycle, so no W-wide combinational priority chain is built.
//
// Ports:
//   clk        - clock, rising edge
//   arst_n     - asynchronous active-low reset
//   req_vld_i  - request valid
//   req_rdy_o  - request ready (high only in IDLE)
//   req_x_i    - occupancy vector, captured on accept
//   req_sel_i  - one-hot start position, captured on accept
//   rsp_vld_o  - response valid
//   rsp_rdy_i  - response accepted
//   rsp_hit_o  - a clear bit was found
//   rsp_err_o  - req_sel_i was not one-hot
//   rsp_y_o    - one-hot position of the found bit (0 on miss)
//   rsp_pos_o  - binary index of the found bit (0 on miss)
module e_seek #(
    parameter int W    = 16,
    parameter int C    = 4,
    parameter int WRAP = 0
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 req_vld_i,
    output logic                 req_rdy_o,
    input  logic [W-1:0]         req_x_i,
    input  logic [W-1:0]         req_sel_i,
    output logic                 rsp_vld_o,
    input  logic                 rsp_rdy_i,
    output logic                 rsp_hit_o,
    output logic                 rsp_err_o,
    output logic [W-1:0]         rsp_y_o,
    output logic [$clog2(W)-1:0] rsp_pos_o
);

    localparam int PW = $clog2(W);
    // One extra bit so offset counts up to W-1 and chunk bases never wrap.
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } state_t;

    // True when exactly one bit of v is set.
    function automatic logic is_onehot(input logic [W-1:0] v);
        logic seen;
        logic multi;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < W; i++) begin
            multi = multi | (seen & v[i]);
            seen  = seen | v[i];
        end
        return seen & ~multi;
    endfunction

    // Binary index of a one-hot vector (meaningless for non-one-hot input).
    function automatic logic [PW-1:0] onehot_idx(input logic [W-1:0] v);
        logic [PW-1:0] idx;
        idx = {PW{1'b0}};
        for (int i = 0; i < W; i++) begin
            idx = idx | ({PW{v[i]}} & PW'(i));
        end
        return idx;
    endfunction

    // One-hot vector with bit idx set.
    function automatic logic [W-1:0] idx_onehot(input logic [PW-1:0] idx);
        logic [W-1:0] one;
        one = {{(W-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

    state_t          state_r;
    logic [W-1:0]    x_r;
    logic [PW-1:0]   s_idx_r;
    logic [CW-1:0]   n_r;
    logic [CW-1:0]   base_r;     // offset of the current chunk minus one (j*C)
    logic            req_rdy_r;
    logic            rsp_vld_r;
    logic            rsp_hit_r;
    logic            rsp_err_r;
    logic [W-1:0]    rsp_y_r;
    logic [PW-1:0]   rsp_pos_r;

    logic            sel_ok_s;
    logic [PW-1:0]   sel_idx_s;
    logic            start_set_s;
    logic [CW-1:0]   n_in_s;
    logic            hit_s;
    logic [PW-1:0]   hit_idx_s;
    logic            last_s;
    logic [31:0]     off_s;
    logic [PW-1:0]   idx_s;

    // Decode the incoming request: validity of sel, start index, offset count.
    always_comb begin
        sel_ok_s    = is_onehot(req_sel_i);
        sel_idx_s   = onehot_idx(req_sel_i);
        start_set_s = req_x_i[sel_idx_s];
        if (WRAP != 0) begin
            n_in_s = CW'(W - 1);
        end else begin
            n_in_s = CW'(sel_idx_s);
        end
    end

    // Examine offsets base+1 .. base+C (clipped to N); lowest offset wins.
    always_comb begin
        hit_s     = 1'b0;
        hit_idx_s = {PW{1'b0}};
        off_s     = 32'd0;
        idx_s     = {PW{1'b0}};
        for (int i = 0; i < C; i++) begin
            off_s = 32'(base_r) + 32'(i) + 32'd1;
            // Index (s - off) mod W, computed without negative intermediates.
            if (32'(s_idx_r) >= off_s) begin
                idx_s = PW'(32'(s_idx_r) - off_s);
            end else begin
                idx_s = PW'(32'(s_idx_r) + 32'(W) - off_s);
            end
            if (!hit_s && (off_s <= 32'(n_r)) && !x_r[idx_s]) begin
                hit_s     = 1'b1;
                hit_idx_s = idx_s;
            end else begin
                hit_s     = hit_s;
            end
        end
        last_s = (32'(base_r) + 32'(C)) >= 32'(n_r);
    end

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r   <= IDLE;
            x_r       <= {W{1'b0}};
            s_idx_r   <= {PW{1'b0}};
            n_r       <= {CW{1'b0}};
            base_r    <= {CW{1'b0}};
            req_rdy_r <= 1'b1;
            rsp_vld_r <= 1'b0;
            rsp_hit_r <= 1'b0;
            rsp_err_r <= 1'b0;
            rsp_y_r   <= {W{1'b0}};
            rsp_pos_r <= {PW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_vld_i) begin
                        x_r       <= req_x_i;
                        s_idx_r   <= sel_idx_s;
                        n_r       <= n_in_s;
                        base_r    <= {CW{1'b0}};
                        req_rdy_r <= 1'b0;
                        rsp_hit_r <= 1'b0;
                        rsp_y_r   <= {W{1'b0}};
                        rsp_pos_r <= {PW{1'b0}};
                        if (!sel_ok_s) begin
                            state_r   <= RESP;
                            rsp_vld_r <= 1'b1;
                            rsp_err_r <= 1'b1;
                        end else if (!start_set_s || (n_in_s == {CW{1'b0}})) begin
                            state_r   <= RESP;
                            rsp_vld_r <= 1'b1;
                            rsp_err_r <= 1'b0;
                        end else begin
                            state_r   <= SCAN;
                            rsp_err_r <= 1'b0;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SCAN: begin
                    if (hit_s) begin
                        state_r   <= RESP;
                        rsp_vld_r <= 1'b1;
                        rsp_hit_r <= 1'b1;
                        rsp_y_r   <= idx_onehot(hit_idx_s);
                        rsp_pos_r <= hit_idx_s;
                    end else if (last_s) begin
                        state_r   <= RESP;
                        rsp_vld_r <= 1'b1;
                    end else begin
                        base_r <= base_r + CW'(C);
                    end
                end
                RESP: begin
                    if (rsp_rdy_i) begin
                        state_r   <= IDLE;
                        req_rdy_r <= 1'b1;
                        rsp_vld_r <= 1'b0;
                        rsp_hit_r <= 1'b0;
                        rsp_err_r <= 1'b0;
                        rsp_y_r   <= {W{1'b0}};
                        rsp_pos_r <= {PW{1'b0}};
                    end else begin
                        state_r <= RESP;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    req_rdy_r <= 1'b1;
                    rsp_vld_r <= 1'b0;
                end
            endcase
        end
    end

    assign req_rdy_o = req_rdy_r;
    assign rsp_vld_o = rsp_vld_r;
    assign rsp_hit_o = rsp_hit_r;
    assign rsp_err_o = rsp_err_r;
    assign rsp_y_o   = rsp_y_r;
    assign rsp_pos_o = rsp_pos_r;

endmodule

// File: tb/tb_e_seek.sv
// Scoreboard bench for e_seek. Three scoreboarded instances:
//   0: W=8 C=2 WRAP=0, 1: W=8 C=2 WRAP=1, 2: W=5 C=3 WRAP=1
// plus a W=16 C=1 instance used for the mid-scan reset scenario.
`timescale 1ns/1ps
module tb_e_seek;

    typedef struct {
        int          dut;
        logic        hit;
        logic        err;
        logic [15:0] y;
        int          pos;
        int          lat;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    exp_t sbq[$];

    logic       arst_n;
    logic       arst_c_n;
    logic [2:0] vld_i;
    logic [2:0] rr;
    logic [2:0] rdy_o, vld_o, hit_o, err_o;
    logic [7:0] xa, sa, xb, sb;
    logic [4:0] xd, sd;
    logic [7:0] y_a, y_b;
    logic [4:0] y_d;
    logic [2:0] pos_a, pos_b, pos_d;
    logic [15:0] y_o [3];
    logic [3:0]  pos_o [3];

    logic        vc, rrc, rdyc, vldc, hitc, errc;
    logic [15:0] xc, sc, yc;
    logic [3:0]  posc;

    assign y_o[0]   = {8'd0, y_a};
    assign y_o[1]   = {8'd0, y_b};
    assign y_o[2]   = {11'd0, y_d};
    assign pos_o[0] = {1'b0, pos_a};
    assign pos_o[1] = {1'b0, pos_b};
    assign pos_o[2] = {1'b0, pos_d};

    e_seek #(.W(8), .C(2), .WRAP(0)) dut_a (
        .clk(clk), .arst_n(arst_n), .req_vld_i(vld_i[0]), .req_rdy_o(rdy_o[0]),
        .req_x_i(xa), .req_sel_i(sa), .rsp_vld_o(vld_o[0]), .rsp_rdy_i(rr[0]),
        .rsp_hit_o(hit_o[0]), .rsp_err_o(err_o[0]), .rsp_y_o(y_a), .rsp_pos_o(pos_a));

    e_seek #(.W(8), .C(2), .WRAP(1)) dut_b (
        .clk(clk), .arst_n(arst_n), .req_vld_i(vld_i[1]), .req_rdy_o(rdy_o[1]),
        .req_x_i(xb), .req_sel_i(sb), .rsp_vld_o(vld_o[1]), .rsp_rdy_i(rr[1]),
        .rsp_hit_o(hit_o[1]), .rsp_err_o(err_o[1]), .rsp_y_o(y_b), .rsp_pos_o(pos_b));

    e_seek #(.W(5), .C(3), .WRAP(1)) dut_d (
        .clk(clk), .arst_n(arst_n), .req_vld_i(vld_i[2]), .req_rdy_o(rdy_o[2]),
        .req_x_i(xd), .req_sel_i(sd), .rsp_vld_o(vld_o[2]), .rsp_rdy_i(rr[2]),
        .rsp_hit_o(hit_o[2]), .rsp_err_o(err_o[2]), .rsp_y_o(y_d), .rsp_pos_o(pos_d));

    e_seek #(.W(16), .C(1), .WRAP(0)) dut_c (
        .clk(clk), .arst_n(arst_c_n), .req_vld_i(vc), .req_rdy_o(rdyc),
        .req_x_i(xc), .req_sel_i(sc), .rsp_vld_o(vldc), .rsp_rdy_i(rrc),
        .rsp_hit_o(hitc), .rsp_err_o(errc), .rsp_y_o(yc), .rsp_pos_o(posc));

    function automatic exp_t mk(int g, logic hit, logic err, logic [15:0] y, int pos, int lat);
        exp_t e;
        e.dut = g; e.hit = hit; e.err = err; e.y = y; e.pos = pos; e.lat = lat; e.acc = 0;
        return e;
    endfunction

    // Reference model: walk offsets k = 1..N from s, index (s-k) mod W.
    function automatic exp_t model(int g, logic [15:0] x, logic [15:0] sel);
        exp_t e;
        int w, c, wrap, ones, s, n, idx;
        case (g)
            0: begin w = 8; c = 2; wrap = 0; end
            1: begin w = 8; c = 2; wrap = 1; end
            default: begin w = 5; c = 3; wrap = 1; end
        endcase
        e = mk(g, 1'b0, 1'b0, 16'h0000, 0, 1);
        ones = 0;
        s = 0;
        for (int i = 0; i < w; i++) begin
            if (sel[i]) begin ones++; s = i; end
        end
        if (ones != 1) begin e.err = 1'b1; return e; end
        if (!x[s]) return e;
        n = (wrap != 0) ? w - 1 : s;
        if (n == 0) return e;
        for (int k = 1; k <= n; k++) begin
            idx = (s - k + w) % w;
            if (!x[idx]) begin
                e.hit = 1'b1; e.pos = idx; e.y = 16'h0001 << idx; e.lat = (k - 1) / c + 2;
                return e;
            end
        end
        e.lat = (n + c - 1) / c + 1;
        return e;
    endfunction

    task automatic drive(int g, logic v, logic [15:0] x, logic [15:0] sel);
        case (g)
            0: begin vld_i[0] = v; xa = x[7:0]; sa = sel[7:0]; end
            1: begin vld_i[1] = v; xb = x[7:0]; sb = sel[7:0]; end
            default: begin vld_i[2] = v; xd = x[4:0]; sd = sel[4:0]; end
        endcase
    endtask

    task automatic issue(int g, logic [15:0] x, logic [15:0] sel, exp_t e);
        int t;
        @(posedge clk); #1;
        drive(g, 1'b1, x, sel);
        t = 0;
        while (!rdy_o[g] && t < 50) begin @(posedge clk); #1; t++; end
        if (!rdy_o[g]) begin
            checks++; failures++;
            $display("FAIL accept_timeout dut%0d: req_rdy_o=%b, need 1", g, rdy_o[g]);
            drive(g, 1'b0, x, sel);
            return;
        end
        e.acc = cyc + 1;
        sbq.push_back(e);
        @(posedge clk); #1;
        drive(g, 1'b0, x, sel);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 100) begin @(posedge clk); #1; t++; end
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: outstanding=%0d, need 0", sbq.size());
            sbq.delete();
        end
    endtask

    logic [2:0]  seen, own, hh, he;
    logic [15:0] hy [3];
    logic [3:0]  hp [3];

    initial begin
        int t;
        logic sawv;
        logic [15:0] sel;
        arst_n = 1'b0; arst_c_n = 1'b0;
        vld_i = 3'b000; rr = 3'b111; vc = 1'b0; rrc = 1'b1;
        xa = 8'h00; sa = 8'h00; xb = 8'h00; sb = 8'h00; xd = 5'h00; sd = 5'h00;
        xc = 16'h0000; sc = 16'h0000;
        seen = 3'b000; own = 3'b000; hh = 3'b000; he = 3'b000;
        for (int g = 0; g < 3; g++) begin hy[g] = 16'h0000; hp[g] = 4'h0; end
        repeat (3) @(posedge clk);
        #1;
        arst_n = 1'b1; arst_c_n = 1'b1;

        checks++;
        if (rdy_o !== 3'b111 || rdyc !== 1'b1) begin
            failures++; $display("FAIL reset_rdy: got %b/%b, need 111/1", rdy_o, rdyc);
        end
        checks++;
        if (vld_o !== 3'b000 || hit_o !== 3'b000 || err_o !== 3'b000 || y_a !== 8'h00 ||
            pos_a !== 3'd0 || vldc !== 1'b0 || yc !== 16'h0000 || posc !== 4'd0) begin
            failures++;
            $display("FAIL reset_rsp: got vld=%b hit=%b err=%b y=%h pos=%0d, need all 0",
                     vld_o, hit_o, err_o, y_a, pos_a);
        end

        // Monitor: pops and compares whenever an instance presents a response.
        fork
            forever begin
                @(negedge clk);
                for (int g = 0; g < 3; g++) begin
                    if (vld_o[g]) begin
                        checks++;
                        if (!seen[g]) begin
                            seen[g] = 1'b1;
                            hh[g] = hit_o[g]; he[g] = err_o[g]; hy[g] = y_o[g]; hp[g] = pos_o[g];
                            if (sbq.size() == 0 || sbq[0].dut != g) begin
                                failures++; own[g] = 1'b0;
                                $display("FAIL unexpected_rsp dut%0d: got rsp_vld_o=1, need 0", g);
                            end else begin
                                own[g] = 1'b1;
                                if (cyc - sbq[0].acc + 1 != sbq[0].lat) begin
                                    failures++;
                                    $display("FAIL latency dut%0d: got T%0d, need T%0d",
                                             g, cyc - sbq[0].acc + 1, sbq[0].lat);
                                end
                            end
                        end else begin
                            if (hit_o[g] != hh[g] || err_o[g] != he[g] || y_o[g] != hy[g] || pos_o[g] != hp[g]) begin
                                failures++;
                                $display("FAIL rsp_stable dut%0d: got y=%h pos=%0d, need y=%h pos=%0d",
                                         g, y_o[g], pos_o[g], hy[g], hp[g]);
                            end
                        end
                        checks++;
                        if (rdy_o[g]) begin
                            failures++;
                            $display("FAIL rdy_busy dut%0d: got req_rdy_o=1, need 0", g);
                        end
                        if (rr[g]) begin
                            if (own[g]) begin
                                checks++;
                                if (hit_o[g] != sbq[0].hit || err_o[g] != sbq[0].err ||
                                    y_o[g] != sbq[0].y || pos_o[g] != 4'(sbq[0].pos)) begin
                                    failures++;
                                    $display("FAIL rsp dut%0d: got hit=%b err=%b y=%h pos=%0d, need hit=%b err=%b y=%h pos=%0d",
                                             g, hit_o[g], err_o[g], y_o[g], pos_o[g],
                                             sbq[0].hit, sbq[0].err, sbq[0].y, sbq[0].pos);
                                end
                                void'(sbq.pop_front());
                            end
                            seen[g] = 1'b0;
                            own[g]  = 1'b0;
                        end
                    end
                end
            end
        join_none

        // Directed vectors, W=8 C=2 WRAP=0.
        issue(0, 16'h00EF, 16'h0080, mk(0, 1'b1, 1'b0, 16'h0010, 4, 3)); drain();
        issue(0, 16'h00DF, 16'h0020, mk(0, 1'b0, 1'b0, 16'h0000, 0, 1)); drain();
        issue(0, 16'h00BF, 16'h0004, mk(0, 1'b0, 1'b0, 16'h0000, 0, 2)); drain();
        issue(0, 16'h00FF, 16'h0003, mk(0, 1'b0, 1'b1, 16'h0000, 0, 1)); drain();
        issue(0, 16'h00FF, 16'h0000, mk(0, 1'b0, 1'b1, 16'h0000, 0, 1)); drain();
        issue(0, 16'h00FF, 16'h0001, mk(0, 1'b0, 1'b0, 16'h0000, 0, 1)); drain();
        issue(0, 16'h0008, 16'h0008, mk(0, 1'b1, 1'b0, 16'h0004, 2, 2)); drain();
        // Directed vectors, W=8 C=2 WRAP=1.
        issue(1, 16'h00BF, 16'h0004, mk(1, 1'b1, 1'b0, 16'h0040, 6, 3)); drain();
        issue(1, 16'h007F, 16'h0001, mk(1, 1'b1, 1'b0, 16'h0080, 7, 2)); drain();
        issue(1, 16'h00FF, 16'h0001, mk(1, 1'b0, 1'b0, 16'h0000, 0, 5)); drain();
        issue(1, 16'h00FF, 16'h0081, mk(1, 1'b0, 1'b1, 16'h0000, 0, 1)); drain();

        // Backpressure: hold the response while new requests are offered.
        rr[0] = 1'b0;
        issue(0, 16'h00FE, 16'h0080, mk(0, 1'b1, 1'b0, 16'h0001, 0, 5));
        t = 0;
        while (!vld_o[0] && t < 20) begin @(posedge clk); #1; t++; end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            drive(0, 1'b1, 16'(i * 37 + 5), 16'h0004);
        end
        @(posedge clk); #1;
        drive(0, 1'b0, 16'h0000, 16'h0000);
        rr[0] = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rdy_o[0] !== 1'b1) begin
            failures++; $display("FAIL rdy_after_release: got %b, need 1", rdy_o[0]);
        end
        drain();
        issue(0, 16'h00FF, 16'h0010, mk(0, 1'b0, 1'b0, 16'h0000, 0, 3)); drain();

        // Sweeps against the reference model.
        for (int g = 0; g < 3; g++) begin
            for (int x = 0; x < ((g == 2) ? 32 : 256); x++) begin
                for (int si = 0; si < ((g == 2) ? 32 : 8); si++) begin
                    sel = (g == 2) ? 16'(si) : (16'h0001 << si);
                    issue(g, 16'(x), sel, model(g, 16'(x), sel));
                    drain();
                end
            end
        end

        // Reset in the middle of a long scan on the W=16 C=1 instance.
        @(posedge clk); #1;
        vc = 1'b1; xc = 16'hFFFE; sc = 16'h8000;
        checks++;
        if (rdyc !== 1'b1) begin failures++; $display("FAIL c_accept: got rdy=%b, need 1", rdyc); end
        @(posedge clk); #1;
        vc = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        arst_c_n = 1'b0;
        #1;
        checks++;
        if (vldc !== 1'b0 || rdyc !== 1'b1) begin
            failures++; $display("FAIL c_reset: got vld=%b rdy=%b, need vld=0 rdy=1", vldc, rdyc);
        end
        @(posedge clk); #1;
        arst_c_n = 1'b1;
        sawv = 1'b0;
        repeat (30) begin @(negedge clk); if (vldc) sawv = 1'b1; end
        checks++;
        if (sawv) begin failures++; $display("FAIL c_dropped: got rsp_vld_o=1 after reset, need 0"); end

        // The instance serves a fresh request after the reset.
        @(posedge clk); #1;
        vc = 1'b1; xc = 16'h0002; sc = 16'h0002;
        @(posedge clk); #1;
        vc = 1'b0;
        t = 1;
        while (!vldc && t < 40) begin @(posedge clk); #1; t++; end
        checks++;
        if (t != 2) begin failures++; $display("FAIL c_latency: got T%0d, need T2", t); end
        checks++;
        if (hitc !== 1'b1 || errc !== 1'b0 || yc !== 16'h0001 || posc !== 4'd0) begin
            failures++;
            $display("FAIL c_rsp: got hit=%b err=%b y=%h pos=%0d, need hit=1 err=0 y=0001 pos=0",
                     hitc, errc, yc, posc);
        end
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
